// File: rtl/qoi_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : qoi_bus_arbiter
// Description : Per-cycle arbiter sharing one synchronous memory port between
//               a CPU (always requesting, stalled via cpu_rdy) and a DMA
//               accelerator. DMA wins whenever it requests; with the optional
//               fairness feature, DMA bursts are capped at MAX_BURST cycles
//               after which the CPU gets exactly one cycle.
// Config      : `define QOI_ARB_FAIR_EN to enable the burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
module qoi_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_do,
  output logic              cpu_rdy,
  output logic [7:0]        cpu_di,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       stall_cnt
);

  // The burst counter is 4 bits wide, so the limit must fit in 1..15.
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_range
    $error("qoi_bus_arbiter: MAX_BURST must be in the range 1..15");
  end

  logic        w_dma_own;
  logic        r_rd_dma_q;
  logic [15:0] r_stall_cnt;

`ifdef QOI_ARB_FAIR_EN
  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  logic [3:0] r_burst_cnt;

  // Ownership is gated by rst so grants drop the instant reset asserts.
  assign w_dma_own = rst & dma_req & (r_burst_cnt < C_MAX_BURST);

  // Count consecutive DMA cycles; any CPU-owned cycle restarts the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_cnt <= '0;
    end else if (w_dma_own) begin
      if (r_burst_cnt != C_MAX_BURST) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
    end else begin
      r_burst_cnt <= '0;
    end
  end
`else
  // Strict priority: DMA owns the bus whenever it requests.
  assign w_dma_own = rst & dma_req;
`endif

  // Memory port follows the owner; a stalled CPU write never reaches memory.
  assign mem_addr  = w_dma_own ? dma_addr  : cpu_ab;
  assign mem_wdata = w_dma_own ? dma_wdata : cpu_do;
  assign mem_we    = rst & (w_dma_own ? dma_we : cpu_we);

  assign dma_gnt    = w_dma_own;
  assign cpu_rdy    = ~w_dma_own;
  assign dma_rvalid = r_rd_dma_q;
  assign dma_rdata  = mem_rdata;
  assign cpu_di     = mem_rdata;
  assign stall_cnt  = r_stall_cnt;

  // Remember a granted DMA read so its data is flagged valid next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_dma_q <= 1'b0;
    end else begin
      r_rd_dma_q <= w_dma_own & ~dma_we;
    end
  end

  // Count CPU stall cycles; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_dma_own) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qoi_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_qoi_bus_arbiter
// Description : Scoreboard bench for qoi_bus_arbiter (MAX_BURST = 4). Builds
//               with or without QOI_ARB_FAIR_EN and expects the matching
//               grant patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qoi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] stall_cnt;

  qoi_bus_arbiter #(.MAX_BURST(4), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ab     (cpu_ab),
    .cpu_we     (cpu_we),
    .cpu_do     (cpu_do),
    .cpu_rdy    (cpu_rdy),
    .cpu_di     (cpu_di),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_we     (dma_we),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory model with a bench-side preload port.
  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic        gnt;
    logic        rdy;
    logic        rv;
    logic        mwe;
    logic [15:0] maddr;
    logic [7:0]  mwd;
  } cyc_t;

  cyc_t       q_cyc[$];
  logic [7:0] q_rd[$];
  logic [7:0] q_cpu[$];

  int          n_vec = 0;
  int          n_err = 0;
  logic        trk = 1'b0;
  logic        cpu_chk = 1'b0;
  logic        prev_rd = 1'b0;
  logic [15:0] exp_stall = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the hand-computed expectation.
  task automatic cycle(input logic req, input logic [15:0] da, input logic dwe,
                       input logic [7:0] dwd, input logic [15:0] ca, input logic cwe,
                       input logic [7:0] cdo, input logic eg, input logic [7:0] dexp,
                       input logic cchk, input logic [7:0] cexp);
    cyc_t e;
    dma_req = req; dma_addr = da; dma_we = dwe; dma_wdata = dwd;
    cpu_ab = ca; cpu_we = cwe; cpu_do = cdo;
    e.gnt   = eg;
    e.rdy   = ~eg;
    e.rv    = prev_rd;
    e.mwe   = eg ? dwe : cwe;
    e.maddr = eg ? da : ca;
    e.mwd   = eg ? dwd : cdo;
    q_cyc.push_back(e);
    if (eg && !dwe) q_rd.push_back(dexp);
    if (cchk) q_cpu.push_back(cexp);
    cpu_chk   = cchk;
    prev_rd   = eg & ~dwe;
    exp_stall = exp_stall + {15'd0, eg};
    trk       = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  initial begin
    cyc_t       e;
    logic [7:0] d;
    logic       cpu_pend;
    cpu_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_pend) begin
        cpu_pend = 1'b0;
        if (q_cpu.size() > 0) begin
          d = q_cpu.pop_front();
          chk("cpu_di", {24'd0, cpu_di}, {24'd0, d});
        end
      end
      if (cpu_chk && cpu_rdy && !cpu_we) cpu_pend = 1'b1;
      if (trk && q_cyc.size() > 0) begin
        e = q_cyc.pop_front();
        chk("gnt_rdy", {30'd0, dma_gnt, cpu_rdy}, {30'd0, e.gnt, e.rdy});
        chk("rvalid", {31'd0, dma_rvalid}, {31'd0, e.rv});
        chk("mem_port", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, e.mwe, e.maddr, e.mwd});
        if (dma_rvalid && q_rd.size() > 0) begin
          d = q_rd.pop_front();
          chk("dma_rdata", {24'd0, dma_rdata}, {24'd0, d});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  pat10;
    logic [19:0] pat20;
    logic [5:0]  pat6;
    logic [15:0] s0;
    rst = 1'b0;
    dma_req = 0; dma_addr = '0; dma_we = 0; dma_wdata = '0;
    cpu_ab = '0; cpu_we = 0; cpu_do = '0;
    #1;
    pre_we = 1'b1; pre_addr = 16'h8000; pre_data = 8'hA5;
    @(posedge clk); #1;
    pre_addr = 16'h9010; pre_data = 8'h3C;
    @(posedge clk); #1;
    pre_we = 1'b0;

    // Reset state with live requests from both masters.
    dma_req = 1; dma_we = 1; dma_addr = 16'h9000; cpu_we = 1;
    #2;
    chk("reset_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    dma_req = 0; dma_we = 0; cpu_we = 0;
    rst = 1'b1;

    // CPU-only read of 0x8000 -> A5, no stalls.
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 1, 8'hA5);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("stall_cpu_only", {16'd0, stall_cnt}, 32'd0);

    // Single DMA read of 0x9010 -> 3C valid on the following cycle only.
    cycle(1, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
    cycle(0, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    cycle(0, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("stall_dma_read", {16'd0, stall_cnt}, 32'd1);

    // Colliding writes: DMA first, stalled CPU write issued next cycle.
    cycle(1, 16'h9000, 1, 8'h11, 16'h0200, 1, 8'h55, 1, 8'h00, 0, 8'h00);
    cycle(0, 16'h9000, 1, 8'h11, 16'h0200, 1, 8'h55, 0, 8'h00, 0, 8'h00);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("mem_dma_write", {24'd0, mem[16'h9000]}, 32'h11);
    chk("mem_cpu_write", {24'd0, mem[16'h0200]}, 32'h55);

    // Long DMA request: burst-limited or strict priority.
    s0 = stall_cnt;
`ifdef QOI_ARB_FAIR_EN
    pat10 = 10'b1111011110;
    for (int i = 0; i < 10; i++)
      cycle(1, 16'h9100, 1, 8'h77, 16'h8000, 0, 8'h00, pat10[9-i], 8'h00, 0, 8'h00);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("stall_burst_delta", {16'd0, stall_cnt - s0}, 32'd8);
`else
    pat20 = 20'hFFFFF;
    for (int i = 0; i < 20; i++)
      cycle(1, 16'h9100, 1, 8'h77, 16'h8000, 0, 8'h00, pat20[19-i], 8'h00, 0, 8'h00);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("stall_strict_delta", {16'd0, stall_cnt - s0}, 32'd20);
`endif
    chk("stall_total", {16'd0, stall_cnt}, {16'd0, exp_stall});

    // Asynchronous reset two cycles into a DMA read burst.
    cycle(1, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
    cycle(1, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
    trk = 1'b0;
    #2;
    chk("pre_reset_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("pre_reset_rvalid", {31'd0, dma_rvalid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("async_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("async_stall", {16'd0, stall_cnt}, 32'd0);
    chk("async_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("async_mem_we", {31'd0, mem_we}, 32'd0);
    void'(q_rd.pop_back());
    prev_rd = 1'b0;
    exp_stall = '0;
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef QOI_ARB_FAIR_EN
    pat6 = 6'b111101;
`else
    pat6 = 6'b111111;
`endif
    for (int i = 0; i < 6; i++)
      cycle(1, 16'h9010, 0, 8'h00, 16'h8000, 0, 8'h00, pat6[5-i], 8'h3C, 0, 8'h00);
    cycle(0, 16'h0000, 0, 8'h00, 16'h8000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    chk("stall_after_reset", {16'd0, stall_cnt}, {16'd0, exp_stall});

    chk("q_cyc_drained", q_cyc.size(), 32'd0);
    chk("q_rd_drained", q_rd.size(), 32'd0);
    chk("q_cpu_drained", q_cpu.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
